dds_key_tuner: RTL and testbench
================================

// Module: dds_key_tuner
// PURPOSE
// - Upstream control stage for the DDS datapath. Sits between the board push-keys
//   and the DDS waveform/phase-accumulator block.
// - Debounces four active-low keys and turns each clean press into a config edit:
//   wave select, frequency-word up/down, and phase offset step.
// - Presents a registered, always-valid configuration plus a one-cycle update strobe.
// PARAMETERS
// - CNT_MAX    999_999   debounce hold count in sys_clk cycles (20 ms @ 50 MHz)
// - FW         32        frequency tuning word width
// - PW         8         phase offset word width
// - FREQ_INIT  32'd85899 frequency word after reset (~1 kHz @ 50 MHz, FW=32)
// - FREQ_STEP  32'd85899 increment/decrement per press
// - FREQ_MAX   32'd858993459 upper saturation limit (inclusive)
// - FREQ_MIN   32'd85899 lower saturation limit (inclusive)
// - PH_STEP    8'd64     phase offset step per press (90 deg at PW=8)
// PORTS
// - sys_clk    in   1   system clock, all logic on rising edge
// - rst        in   1   asynchronous, active-high reset
// - key        in   4   raw keys, active-low, asynchronous to sys_clk
// - wave_sel   out  4   one-hot wave select: 0001 sine,0010 square,0100 tri,1000 saw
// - freq_word  out  FW  DDS frequency tuning word
// - phase_word out  PW  DDS phase offset word
// - cfg_upd    out  1   one-cycle pulse the cycle after any output changes
// BEHAVIOUR
// - Reset (async, high): wave_sel=4'b0001, freq_word=FREQ_INIT, phase_word=0,
//   cfg_upd=0, all debounce FSMs to IDLE, counters 0, synchronizers to 1 (released).
// - Each key passes a 2-FF synchronizer, then its own FSM with a shared-width counter:
//   IDLE: sync=0 -> PRESS_DB, cnt=0.
//   PRESS_DB: sync=1 -> IDLE; else cnt++; cnt==CNT_MAX -> HELD, emit press pulse.
//   HELD: sync=1 -> REL_DB, cnt=0.
//   REL_DB: sync=0 -> HELD; else cnt++; cnt==CNT_MAX -> IDLE.
// - Press pulse is exactly 1 cycle; press-to-pulse latency = 2 (sync) + CNT_MAX+1 cycles.
// - Actions, registered the cycle after the press pulse:
//   key[0]: rotate wave_sel left 1 (1000 -> 0001).
//   key[1]: freq_word += FREQ_STEP; if result > FREQ_MAX or overflows FW, hold FREQ_MAX.
//   key[2]: freq_word -= FREQ_STEP; if result < FREQ_MIN or underflows, hold FREQ_MIN.
//   key[3]: phase_word += PH_STEP, modulo 2^PW (wraps 192 -> 0).
// - Simultaneous pulses: independent fields all update same cycle; key[1] and key[2]
//   together -> freq_word unchanged.
// - cfg_upd = 1 for one cycle after any field actually changes value; a saturated
//   press that leaves freq_word unchanged produces no cfg_upd.
// - Glitches shorter than CNT_MAX+1 cycles produce no action in either direction.
// - Reset asserted mid-debounce or mid-hold: state discarded; a key still held at
//   release of reset must go through full PRESS_DB before acting.
// CONFIGURATION
// - KEY_REPEAT_EN defined: in HELD, key[1]/key[2] auto-repeat: first repeat pulse
//   after 25*(CNT_MAX+1) cycles held, then one every 5*(CNT_MAX+1) cycles; same
//   saturation rules; key[0]/key[3] never repeat.
// - KEY_REPEAT_EN undefined: one action per press only; repeat counters not built.
// TESTING (bench uses CNT_MAX=15, defaults otherwise)
// - Reset: rst=1 mid-run -> outputs 0001 / 85899 / 0 / cfg_upd=0 immediately.
// - key[0] low for 40 cycles, four times -> wave_sel 0010,0100,1000,0001; 4 cfg_upd.
// - key[1] bounce: 10-cycle low pulses x5 -> no change; then 40-cycle low ->
//   freq_word=171798, cfg_upd pulse 19 cycles after clean low edge.
// - key[2] press at reset value -> freq_word stays 85899, no cfg_upd.
// - key[3] five presses -> phase_word 64,128,192,0,64.
// - key[1]+key[2] pressed same cycle -> freq_word unchanged; with KEY_REPEAT_EN,
//   key[1] held 1000 cycles -> first step at ~400+19, then every 80 cycles.

Source files
------------

// File: rtl/dds_key_tuner_if.sv
// Configuration bus between the key tuner and the DDS datapath.
// The tuner (master) drives the configuration fields and the update strobe;
// the board-side consumer (slave) drives the raw active-low keys.
interface dds_key_tuner_if #(
    parameter int FW = 32,
    parameter int PW = 8
);
    logic [3:0]    key;
    logic [3:0]    wave_sel;
    logic [FW-1:0] freq_word;
    logic [PW-1:0] phase_word;
    logic          cfg_upd;

    modport master (
        input  key,
        output wave_sel,
        output freq_word,
        output phase_word,
        output cfg_upd
    );

    modport slave (
        output key,
        input  wave_sel,
        input  freq_word,
        input  phase_word,
        input  cfg_upd
    );
endinterface

// File: rtl/dds_key_tuner.sv
// DDS key tuner: debounces four active-low push keys and turns each clean
// press into a configuration edit (wave select, frequency up/down, phase step).
// Optional feature macro: KEY_REPEAT_EN -- auto-repeat for frequency up/down
// while the key is held (first repeat after 25 debounce periods, then every 5).
module dds_key_tuner #(
    parameter int            CNT_MAX   = 999_999,
    parameter int            FW        = 32,
    parameter int            PW        = 8,
    parameter logic [FW-1:0] FREQ_INIT = 32'd85899,
    parameter logic [FW-1:0] FREQ_STEP = 32'd85899,
    parameter logic [FW-1:0] FREQ_MAX  = 32'd858993459,
    parameter logic [FW-1:0] FREQ_MIN  = 32'd85899,
    parameter logic [PW-1:0] PH_STEP   = 8'd64
) (
    input  logic             sys_clk,
    input  logic             rst,
    dds_key_tuner_if.master  cfg
);

    localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } db_state_t;

    logic [3:0]    sync_meta;
    logic [3:0]    sync_key;
    logic [3:0]    act;        // one-cycle action request per key

    logic [3:0]    wave_q,  wave_d;
    logic [FW-1:0] freq_q,  freq_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          upd_q;
    logic          changed;

    logic [FW:0]   freq_sum;
    logic [FW:0]   freq_diff;

    // Two-flop synchronizer; resets to "released" so no phantom press follows reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_meta <= 4'hF;
            sync_key  <= 4'hF;
        end else begin
            sync_meta <= cfg.key;
            sync_key  <= sync_meta;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        db_state_t     state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_i;

        // Debounce FSM state and hold counter.
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Debounce next-state: a level must persist CNT_MAX+1 cycles to be accepted.
        always_comb begin
            // NOTE: every always_comb output gets a default first so no path infers a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            press_i = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sync_key[i]) begin
                        state_d = PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                PRESS_DB: begin
                    if (sync_key[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == CW'(CNT_MAX)) begin
                        state_d = HELD;
                        press_i = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (sync_key[i]) begin
                        state_d = REL_DB;
                        cnt_d   = '0;
                    end
                end
                REL_DB: begin
                    if (!sync_key[i]) begin
                        state_d = HELD;
                    end else if (cnt_q == CW'(CNT_MAX)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef KEY_REPEAT_EN
        if (i == 1 || i == 2) begin : g_rep
            localparam int REP_FIRST = 25 * (CNT_MAX + 1);
            localparam int REP_NEXT  = 5 * (CNT_MAX + 1);
            localparam int RW        = $clog2(REP_FIRST);

            logic [RW-1:0] rep_q, rep_d;
            logic          first_q, first_d;
            logic          rep_i;

            // Auto-repeat interval counter.
            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    rep_q   <= '0;
                    first_q <= 1'b1;
                end else begin
                    rep_q   <= rep_d;
                    first_q <= first_d;
                end
            end

            // Repeat timing: long first interval after the press, short ones after that.
            always_comb begin
                rep_d   = rep_q;
                first_d = first_q;
                rep_i   = 1'b0;
                if (press_i) begin
                    rep_d   = '0;
                    first_d = 1'b1;
                end else if (state_q == HELD && !sync_key[i]) begin
                    if (rep_q == (first_q ? RW'(REP_FIRST - 1) : RW'(REP_NEXT - 1))) begin
                        rep_i   = 1'b1;
                        rep_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end

            assign act[i] = press_i | rep_i;
        end else begin : g_norep
            assign act[i] = press_i;
        end
`else
        assign act[i] = press_i;
`endif
    end

    // One extra bit catches wrap-around in both directions before saturation.
    assign freq_sum  = {1'b0, freq_q} + {1'b0, FREQ_STEP};
    assign freq_diff = {1'b0, freq_q} - {1'b0, FREQ_STEP};

    // Next configuration from this cycle's key actions, with saturation and wrap.
    always_comb begin
        wave_d  = wave_q;
        freq_d  = freq_q;
        phase_d = phase_q;
        if (act[0]) begin
            wave_d = {wave_q[2:0], wave_q[3]};
        end
        if (act[1] && !act[2]) begin
            freq_d = (freq_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_sum[FW-1:0];
        end else if (act[2] && !act[1]) begin
            freq_d = (freq_diff[FW] || freq_diff[FW-1:0] < FREQ_MIN) ? FREQ_MIN : freq_diff[FW-1:0];
        end
        if (act[3]) begin
            phase_d = phase_q + PH_STEP;
        end
        changed = (wave_d != wave_q) || (freq_d != freq_q) || (phase_d != phase_q);
    end

    // Configuration register; the strobe rises with the first cycle of a new value.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wave_q  <= 4'b0001;
            freq_q  <= FREQ_INIT;
            phase_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            wave_q  <= wave_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            upd_q   <= changed;
        end
    end

    assign cfg.wave_sel   = wave_q;
    assign cfg.freq_word  = freq_q;
    assign cfg.phase_word = phase_q;
    assign cfg.cfg_upd    = upd_q;

endmodule

// File: tb/tb_dds_key_tuner.sv
// Directed bench for dds_key_tuner with CNT_MAX=15 (16-cycle debounce).
module tb_dds_key_tuner;

    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt = 0;

    dds_key_tuner_if #(.FW(32), .PW(8)) ifc ();

    dds_key_tuner #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .cfg     (ifc)
    );

    always #5 clk = ~clk;

    // Counts strobe cycles, sampled on the falling edge.
    always @(negedge clk) if (ifc.cfg_upd === 1'b1) upd_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a key low for n cycles, release it and let the release debounce finish.
    task automatic press(input int idx, input int n);
        ifc.key[idx] = 1'b0;
        cycles(n);
        ifc.key[idx] = 1'b1;
        cycles(30);
    endtask

    logic [3:0]  wave_exp [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]  phase_exp [5] = '{8'd64, 8'd128, 8'd192, 8'd0, 8'd64};
    int          upd0;
    int          first_k;
    logic [31:0] freq_at19;
    logic [31:0] hold_exp;

    initial begin
        ifc.key = 4'hF;
        cycles(5);
        rst = 1'b0;
        cycles(2);

        // Reset state
        check("reset_wave",  32'(ifc.wave_sel), 32'd1);
        check("reset_freq",  ifc.freq_word, 32'd85899);
        check("reset_phase", 32'(ifc.phase_word), 32'd0);
        check("reset_upd",   32'(ifc.cfg_upd), 32'd0);

        // Wave select rotation with wrap 1000 -> 0001
        upd0 = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            press(0, 40);
            check($sformatf("wave_press%0d", i), 32'(ifc.wave_sel), 32'(wave_exp[i]));
        end
        check("wave_upd_count", upd_cnt - upd0, 4);

        // Bouncy key[1]: short lows must be ignored
        upd0 = upd_cnt;
        for (int i = 0; i < 5; i++) begin
            ifc.key[1] = 1'b0;
            cycles(10);
            ifc.key[1] = 1'b1;
            cycles(10);
        end
        cycles(10);
        check("bounce_freq", ifc.freq_word, 32'd85899);
        check("bounce_upd",  upd_cnt - upd0, 0);

        // Clean key[1] press: strobe 19 cycles after the low edge
        first_k   = 0;
        freq_at19 = '0;
        ifc.key[1] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cycles(1);
            if (ifc.cfg_upd === 1'b1 && first_k == 0) first_k = k;
            if (k == 19) freq_at19 = ifc.freq_word;
        end
        ifc.key[1] = 1'b1;
        cycles(30);
        check("up_latency",  first_k, 19);
        check("up_freq_at19", freq_at19, 32'd171798);
        check("up_freq",     ifc.freq_word, 32'd171798);

        // key[2]: step down to the floor, then a saturated press is silent
        upd0 = upd_cnt;
        press(2, 40);
        check("down_freq", ifc.freq_word, 32'd85899);
        check("down_upd",  upd_cnt - upd0, 1);
        upd0 = upd_cnt;
        press(2, 40);
        check("down_sat_freq", ifc.freq_word, 32'd85899);
        check("down_sat_upd",  upd_cnt - upd0, 0);

        // Phase steps with wrap 192 -> 0
        for (int i = 0; i < 5; i++) begin
            press(3, 40);
            check($sformatf("phase_press%0d", i), 32'(ifc.phase_word), 32'(phase_exp[i]));
        end

        // Up and down together cancel
        press(1, 40);
        check("pre_both_freq", ifc.freq_word, 32'd171798);
        upd0 = upd_cnt;
        ifc.key[2:1] = 2'b00;
        cycles(40);
        ifc.key[2:1] = 2'b11;
        cycles(30);
        check("both_freq", ifc.freq_word, 32'd171798);
        check("both_upd",  upd_cnt - upd0, 0);

        // A short release glitch while held gives no second action
        upd0 = upd_cnt;
        ifc.key[0] = 1'b0;
        cycles(40);
        ifc.key[0] = 1'b1;
        cycles(10);
        ifc.key[0] = 1'b0;
        cycles(40);
        ifc.key[0] = 1'b1;
        cycles(30);
        check("held_glitch_wave", 32'(ifc.wave_sel), 32'd2);
        check("held_glitch_upd",  upd_cnt - upd0, 1);

        // Long hold of key[1]
`ifdef KEY_REPEAT_EN
        hold_exp = 32'd171798 + 32'd9 * 32'd85899;
`else
        hold_exp = 32'd171798 + 32'd85899;
`endif
        press(1, 1000);
        check("hold_freq", ifc.freq_word, hold_exp);

        // Reset mid-debounce with the key still held across reset release
        ifc.key[3] = 1'b0;
        cycles(8);
        rst = 1'b1;
        #1;
        check("midrst_wave",  32'(ifc.wave_sel), 32'd1);
        check("midrst_freq",  ifc.freq_word, 32'd85899);
        check("midrst_phase", 32'(ifc.phase_word), 32'd0);
        check("midrst_upd",   32'(ifc.cfg_upd), 32'd0);
        cycles(3);
        rst = 1'b0;
        cycles(10);
        check("postrst_phase_early", 32'(ifc.phase_word), 32'd0);
        cycles(15);
        check("postrst_phase_late",  32'(ifc.phase_word), 32'd64);
        ifc.key[3] = 1'b1;
        cycles(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
